// File: rtl/sevenseg_bcd_scanner_if.sv
`default_nettype none
// ============================================================================
//  Module   : sevenseg_bcd_scanner_if
//  Purpose  : Bundles the value/load/blank controls and the panel drive pins
//             of the seven-segment BCD scanner.
//  Signals  : value[13:0] binary value to display
//             load        single-cycle capture strobe for value
//             blank_lz    1 = suppress leading zeros
//             busy        conversion in progress
//             AN[3:0]     active-low digit enables, AN[3] = leftmost digit
//             seg[6:0]    active-low segments {a,b,c,d,e,f,g}
//             DP          decimal point (always off)
//  Modports : master - drives value/load/blank_lz, observes the panel pins
//             slave  - the scanner itself
//  Revision : 1.0  initial release
// ============================================================================
interface sevenseg_bcd_scanner_if;
   logic [13:0] value;
   logic        load;
   logic        blank_lz;
   logic        busy;
   logic [3:0]  AN;
   logic [6:0]  seg;
   logic        DP;

   modport master (
      output value, load, blank_lz,
      input  busy, AN, seg, DP
   );

   modport slave (
      input  value, load, blank_lz,
      output busy, AN, seg, DP
   );
endinterface
`default_nettype wire

// File: rtl/sevenseg_bcd_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : sevenseg_bcd_scanner
//  Purpose  : Captures a 14-bit binary value, converts it to four BCD digits
//             with a sequential double-dabble FSM (14 clk), and multiplexes
//             the digits onto active-low anode/segment pins.
//  Ports    : clk  - system clock, rising edge
//             rst  - asynchronous, active-low reset
//             bus  - sevenseg_bcd_scanner_if.slave (value, load, blank_lz,
//                    busy, AN, seg, DP)
//  Params   : SCAN_DIV - clk cycles each digit stays lit (>= 2)
//  Revision : 1.0  initial release
// ============================================================================
module sevenseg_bcd_scanner #(
   parameter int SCAN_DIV = 100000
) (
   input  logic                          clk,
   input  logic                          rst,
   sevenseg_bcd_scanner_if.slave         bus
);

   localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t      state;
   state_t      state_next;

   // conversion datapath
   logic [13:0] bin;
   logic [15:0] bcd;
   logic [3:0]  iter;
   logic        ovf_cap;
   logic [15:0] bcd_adj;
   logic [15:0] bcd_shift;
   logic        last_iter;

   // display registers
   logic [15:0] disp;
   logic        disp_valid;
   logic        disp_ovf;

   // scan
   logic [PW-1:0] presc;
   logic          presc_tc;
   logic [1:0]    idx;
   logic [1:0]    idx_next;
   logic [3:0]    an_r;
   logic [6:0]    seg_r;
   logic [6:0]    seg_next;
   logic [3:0]    digit;
   logic          higher_zero;

   // ------------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   assign last_iter = (state == SHIFT) && (iter == 4'd13);

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.load) state_next = SHIFT;
         SHIFT:   if (last_iter) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Double-dabble step: add 3 to every nibble >= 5, then shift {bcd,bin}.
   always_comb begin
      bcd_adj = bcd;
      for (int k = 0; k < 4; k++) begin
         if (bcd[k*4 +: 4] >= 4'd5) bcd_adj[k*4 +: 4] = bcd[k*4 +: 4] + 4'd3;
      end
   end

   assign bcd_shift = {bcd_adj[14:0], bin[13]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bin        <= '0;
         bcd        <= '0;
         iter       <= '0;
         ovf_cap    <= 1'b0;
         disp       <= '0;
         disp_valid <= 1'b0;
         disp_ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.load) begin
                  bin     <= bus.value;
                  ovf_cap <= (bus.value > 14'd9999);
                  bcd     <= '0;
                  iter    <= '0;
               end
            end
            SHIFT: begin
               bcd  <= bcd_shift;
               bin  <= {bin[12:0], 1'b0};
               iter <= iter + 4'd1;
               // Display only changes on the final step: no partial values.
               if (last_iter) begin
                  disp       <= bcd_shift;
                  disp_valid <= 1'b1;
                  disp_ovf   <= ovf_cap;
               end
            end
            default: ;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Scan: segment pattern is computed for the digit about to be lit so that
   // AN and seg switch on the same edge.
   // ------------------------------------------------------------------------
   assign presc_tc = (presc == PW'(SCAN_DIV - 1));
   assign idx_next = idx - 2'd1;
   assign digit    = disp[{idx_next, 2'b00} +: 4];

   always_comb begin
      higher_zero = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if ((k >= int'(idx_next)) && (disp[k*4 +: 4] != 4'd0)) higher_zero = 1'b0;
      end
   end

   always_comb begin
      seg_next = 7'b1111111;
      if (!disp_valid) begin
         seg_next = 7'b1111111;
      end else if (disp_ovf) begin
         seg_next = 7'b1111110;
      end else if (bus.blank_lz && (idx_next != 2'd0) && higher_zero) begin
         seg_next = 7'b1111111;
      end else begin
         case (digit)
            4'd0:    seg_next = 7'b0000001;
            4'd1:    seg_next = 7'b1001111;
            4'd2:    seg_next = 7'b0010010;
            4'd3:    seg_next = 7'b0000110;
            4'd4:    seg_next = 7'b1001100;
            4'd5:    seg_next = 7'b0100100;
            4'd6:    seg_next = 7'b0100000;
            4'd7:    seg_next = 7'b0001111;
            4'd8:    seg_next = 7'b0000000;
            4'd9:    seg_next = 7'b0000100;
            default: seg_next = 7'b1111111;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         presc <= '0;
         idx   <= 2'd3;
         an_r  <= 4'b0111;
         seg_r <= 7'b1111111;
      end else if (presc_tc) begin
         presc <= '0;
         idx   <= idx_next;
         an_r  <= ~(4'b0001 << idx_next);
         seg_r <= seg_next;
      end else begin
         presc <= presc + PW'(1);
      end
   end

   assign bus.busy = (state == SHIFT);
   assign bus.AN   = an_r;
   assign bus.seg  = seg_r;
   assign bus.DP   = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_sevenseg_bcd_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sevenseg_bcd_scanner
//  Purpose  : Self-checking bench for sevenseg_bcd_scanner (SCAN_DIV = 4).
//             Expected segment patterns come from a decimal reference model
//             (division/modulo on the loaded value).
//  Revision : 1.0  initial release
// ============================================================================
module tb_sevenseg_bcd_scanner;

   localparam int SCAN_DIV = 4;
   localparam logic [6:0] SEG_TBL [0:9] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
      7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
   };

   logic clk = 1'b0;
   logic rst = 1'b0;
   sevenseg_bcd_scanner_if bus();

   sevenseg_bcd_scanner #(.SCAN_DIV(SCAN_DIV)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int tests_run = 0;
   int fails     = 0;

   // reference model state
   bit m_valid = 1'b0;
   bit m_ovf   = 1'b0;
   int m_val   = 0;

   function automatic logic [6:0] exp_seg(int idx);
      int p = 1;
      for (int i = 0; i < idx; i++) p = p * 10;
      if (!m_valid) return 7'b1111111;
      if (m_ovf) return 7'b1111110;
      if (bus.blank_lz && idx >= 1 && m_val < p) return 7'b1111111;
      return SEG_TBL[(m_val / p) % 10];
   endfunction

   task automatic model_load(int v);
      m_valid = 1'b1;
      m_val   = v;
      m_ovf   = (v > 9999);
   endtask

   // Stimulus helpers (no checking inside)
   task automatic pulse_load(int v);
      bus.value = 14'(v);
      bus.load  = 1'b1;
      @(posedge clk); #1;
      bus.load  = 1'b0;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (bus.busy === 1'b1 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   // Records seg for each digit over the next four scan slots.
   task automatic capture_slots(output logic [27:0] segs, output logic [3:0] seen,
                                output bit timed_out);
      logic [3:0] prev;
      int changes = 0;
      int cyc = 0;
      segs = '1; seen = '0;
      prev = bus.AN;
      while (changes < 4 && cyc < 60) begin
         @(posedge clk); #1;
         cyc++;
         if (bus.AN !== prev) begin
            prev = bus.AN;
            changes++;
            case (bus.AN)
               4'b1110: begin segs[0*7 +: 7] = bus.seg; seen[0] = 1'b1; end
               4'b1101: begin segs[1*7 +: 7] = bus.seg; seen[1] = 1'b1; end
               4'b1011: begin segs[2*7 +: 7] = bus.seg; seen[2] = 1'b1; end
               4'b0111: begin segs[3*7 +: 7] = bus.seg; seen[3] = 1'b1; end
               default: ;
            endcase
         end
      end
      timed_out = (changes < 4);
   endtask

   // ------------------------------------------------------------------------
   task automatic test_reset();
      logic [3:0] exp_an [4] = '{4'b1011, 4'b1101, 4'b1110, 4'b0111};
      int n = 0;
      int cyc = 0;
      logic [3:0] prev;
      repeat (6) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      tests_run++;
      if (bus.AN !== 4'b0111 || bus.seg !== 7'b1111111 || bus.busy !== 1'b0 || bus.DP !== 1'b1) begin
         fails++;
         $display("FAIL reset_state: AN=%b seg=%b busy=%b DP=%b expected 0111 1111111 0 1",
                  bus.AN, bus.seg, bus.busy, bus.DP);
      end
      m_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      prev = bus.AN;
      while (n < 4 && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         if (bus.AN !== prev) begin
            prev = bus.AN;
            tests_run++;
            if (bus.AN !== exp_an[n] || cyc != 4 * (n + 1)) begin
               fails++;
               $display("FAIL scan_rotation[%0d]: AN=%b at clk %0d expected %b at clk %0d",
                        n, bus.AN, cyc, exp_an[n], 4 * (n + 1));
            end
            tests_run++;
            if (bus.seg !== 7'b1111111) begin
               fails++;
               $display("FAIL blank_before_load[%0d]: seg=%b expected 1111111", n, bus.seg);
            end
            n++;
         end
      end
      tests_run++;
      if (n != 4) begin
         fails++;
         $display("FAIL scan_timeout: saw %0d AN changes expected 4", n);
      end
   endtask

   task automatic test_convert_1234();
      int n;
      logic [27:0] s; logic [3:0] seen; bit to;
      pulse_load(1234);
      wait_idle(n);
      model_load(1234);
      tests_run++;
      if (n != 14) begin
         fails++;
         $display("FAIL busy_len_1234: busy for %0d clk expected 14", n);
      end
      capture_slots(s, seen, to);
      tests_run++;
      if (to || seen !== 4'hF) begin
         fails++;
         $display("FAIL slots_1234: seen=%b timeout=%0d expected 1111 0", seen, to);
      end
      for (int i = 0; i < 4; i++) begin
         tests_run++;
         if (s[i*7 +: 7] !== exp_seg(i)) begin
            fails++;
            $display("FAIL digit_1234[%0d]: seg=%b expected %b", i, s[i*7 +: 7], exp_seg(i));
         end
      end
   endtask

   task automatic test_blank_lz();
      int n;
      logic [27:0] s; logic [3:0] seen; bit to;
      bus.blank_lz = 1'b0;
      pulse_load(7);
      wait_idle(n);
      model_load(7);
      for (int b = 0; b < 2; b++) begin
         bus.blank_lz = b[0];
         capture_slots(s, seen, to);
         for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (to || s[i*7 +: 7] !== exp_seg(i)) begin
               fails++;
               $display("FAIL blank_lz%0d_digit[%0d]: seg=%b expected %b", b, i, s[i*7 +: 7], exp_seg(i));
            end
         end
      end
   endtask

   task automatic test_zero_and_overflow();
      int n;
      int vals [2] = '{0, 10000};
      logic [27:0] s; logic [3:0] seen; bit to;
      bus.blank_lz = 1'b1;
      for (int v = 0; v < 2; v++) begin
         pulse_load(vals[v]);
         wait_idle(n);
         model_load(vals[v]);
         capture_slots(s, seen, to);
         for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (to || s[i*7 +: 7] !== exp_seg(i)) begin
               fails++;
               $display("FAIL value%0d_digit[%0d]: seg=%b expected %b", vals[v], i, s[i*7 +: 7], exp_seg(i));
            end
         end
      end
      bus.blank_lz = 1'b0;
   endtask

   task automatic test_load_while_busy();
      int n;
      logic [27:0] s; logic [3:0] seen; bit to;
      pulse_load(42);
      repeat (2) @(posedge clk);
      #1;
      tests_run++;
      if (bus.busy !== 1'b1) begin
         fails++;
         $display("FAIL busy_at_second_load: busy=%b expected 1", bus.busy);
      end
      pulse_load(99);
      wait_idle(n);
      model_load(42);
      tests_run++;
      if (n != 11) begin
         fails++;
         $display("FAIL busy_remaining: busy for %0d clk expected 11", n);
      end
      repeat (3) @(posedge clk);
      #1;
      tests_run++;
      if (bus.busy !== 1'b0) begin
         fails++;
         $display("FAIL ignored_load_restart: busy=%b expected 0", bus.busy);
      end
      capture_slots(s, seen, to);
      for (int i = 0; i < 4; i++) begin
         tests_run++;
         if (to || s[i*7 +: 7] !== exp_seg(i)) begin
            fails++;
            $display("FAIL keep42_digit[%0d]: seg=%b expected %b", i, s[i*7 +: 7], exp_seg(i));
         end
      end
      pulse_load(99);
      wait_idle(n);
      model_load(99);
      capture_slots(s, seen, to);
      for (int i = 0; i < 4; i++) begin
         tests_run++;
         if (to || s[i*7 +: 7] !== exp_seg(i)) begin
            fails++;
            $display("FAIL show99_digit[%0d]: seg=%b expected %b", i, s[i*7 +: 7], exp_seg(i));
         end
      end
   endtask

   task automatic test_reset_mid_conversion();
      int n;
      logic [27:0] s; logic [3:0] seen; bit to;
      pulse_load(5678);
      repeat (6) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      m_valid = 1'b0;
      tests_run++;
      if (bus.busy !== 1'b0 || bus.seg !== 7'b1111111 || bus.AN !== 4'b0111) begin
         fails++;
         $display("FAIL mid_reset: busy=%b seg=%b AN=%b expected 0 1111111 0111", bus.busy, bus.seg, bus.AN);
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      capture_slots(s, seen, to);
      for (int i = 0; i < 4; i++) begin
         tests_run++;
         if (to || s[i*7 +: 7] !== exp_seg(i)) begin
            fails++;
            $display("FAIL after_reset_digit[%0d]: seg=%b expected %b", i, s[i*7 +: 7], exp_seg(i));
         end
      end
      pulse_load(5678);
      wait_idle(n);
      model_load(5678);
      tests_run++;
      if (n != 14) begin
         fails++;
         $display("FAIL busy_len_5678: busy for %0d clk expected 14", n);
      end
      capture_slots(s, seen, to);
      for (int i = 0; i < 4; i++) begin
         tests_run++;
         if (to || s[i*7 +: 7] !== exp_seg(i)) begin
            fails++;
            $display("FAIL digit_5678[%0d]: seg=%b expected %b", i, s[i*7 +: 7], exp_seg(i));
         end
      end
   endtask

   task automatic test_random();
      int n;
      int v;
      logic [27:0] s; logic [3:0] seen; bit to;
      for (int t = 0; t < 12; t++) begin
         v = (t % 4 == 0) ? int'($urandom_range(0, 99)) : int'($urandom_range(0, 16383));
         bus.blank_lz = 1'($urandom_range(0, 1));
         pulse_load(v);
         wait_idle(n);
         model_load(v);
         tests_run++;
         if (n != 14) begin
            fails++;
            $display("FAIL rand_busy_len v=%0d: busy for %0d clk expected 14", v, n);
         end
         capture_slots(s, seen, to);
         for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (to || s[i*7 +: 7] !== exp_seg(i)) begin
               fails++;
               $display("FAIL rand v=%0d blz=%0d digit[%0d]: seg=%b expected %b",
                        v, bus.blank_lz, i, s[i*7 +: 7], exp_seg(i));
            end
         end
      end
   endtask

   initial begin
      bus.value    = '0;
      bus.load     = 1'b0;
      bus.blank_lz = 1'b0;
      rst          = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      test_reset();
      test_convert_1234();
      test_blank_lz();
      test_zero_and_overflow();
      test_load_while_busy();
      test_reset_mid_conversion();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sevenseg_bcd_scanner.md
Name: sevenseg_bcd_scanner

Overview:
Display back-end for the four-digit seven-segment panel. It captures a 14-bit binary value and converts it to four BCD digits with a sequential double-dabble FSM. It then time-multiplexes the digits onto the active-low anode and segment pins. It sits downstream of the counter/datapath core, replacing the fixed two-digit lookup and free-running anode rotation in the top-level wrapper.

Parameters:
SCAN_DIV, 100000, clk cycles each digit stays lit (1 kHz per digit at 100 MHz); minimum 2.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  asynchronous, active-low reset.
value  input  14  binary value to display.
load  input  1  single-cycle capture strobe for value.
blank_lz  input  1  1 = suppress leading zeros.
busy  output  1  conversion in progress.
AN  output  4  active-low digit enables, one-hot-low; AN[3] = leftmost digit.
seg  output  7  active-low segments, seg[6:0] = {a,b,c,d,e,f,g}.
DP  output  1  decimal point, constant 1 (off).

Behaviour:
- Reset (rst=0, asynchronous):
  - AN=4'b0111, seg=7'b1111111, busy=0.
  - FSM state IDLE, prescaler=0, display registers cleared, disp_valid=0.
- Conversion FSM states: IDLE, SHIFT.
  - IDLE: load=1 captures value and sets ovf=(value>9999). It clears the 16-bit BCD accumulator, sets iteration count=0, and goes to SHIFT. busy=1 from the next cycle.
  - SHIFT: one iteration per clk. Add 3 to every BCD nibble >=5, then shift {bcd,bin} left by 1.
  - After the 14th iteration (edge 14 after the load edge), the result is written to the display digit registers. The same edge sets disp_valid=1, latches ovf, and returns to IDLE with busy=0.
  - Total latency: load edge + 14 clk.
  - load while busy=1 is ignored; the in-flight conversion completes unchanged.
  - The display keeps the previous digits until the update edge, so no partial values are ever shown.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1, free-running.
  - On terminal count, the active digit advances 3→2→1→0→3. AN sequence is 0111→1011→1101→1110→0111.
  - AN and seg are both registered and update on the same edge, so there is no ghosting.
- Segment selection for the active digit, in priority order:
  1. disp_valid=0 → 1111111 (blank).
  2. ovf=1 → 1111110 (dash, g only) on all digits.
  3. blank_lz=1, digit index ≥1, and this digit and all higher digits are 0 → 1111111. Digit 0 is never blanked.
  4. Otherwise, the BCD code in active-low form:
     - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
     - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
     - Any non-BCD nibble → 1111111.
- blank_lz is sampled combinationally into the registered seg every cycle; a change takes effect at the next scan edge.
- Reset mid-conversion aborts the conversion: the display returns to blank, and the next load operates normally.

Test Plan:
1. Hold rst=0 mid-scan, then release → AN=0111, seg=1111111, busy=0, DP=1. With SCAN_DIV=4, AN rotates every 4 clk through 0111, 1011, 1101, 1110.
2. SCAN_DIV=4, load value=1234 → busy=1 for exactly 14 clk. Afterwards the digit 3/2/1/0 slots show 1001111 / 0010010 / 0000110 / 1001100.
3. load value=7: blank_lz=0 → digits 3..1 = 0000001, digit0 = 0001111. blank_lz=1 → digits 3..1 = 1111111, digit0 = 0001111.
4. load value=0 with blank_lz=1 → only digit0 lit, 0000001. Then load value=10000 → all four digits 1111110.
5. load value=42, then load value=99 three clk later (busy=1) → display settles to 0,0,4,2. A 99 load after busy=0 → 0,0,9,9.
6. Assert rst=0 at clk 7 of a conversion of 5678 → busy=0 and seg blank immediately. After release, load 5678 → 0100100 / 0100000 / 0001111 / 0000000.
